seven_segment_scan_decoder: RTL and testbench
=============================================

Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver.
- Samples the active-low SEG/DIG scan lines and waits for each digit slot to hold stable.
- Decodes each segment pattern back to a hex nibble and reassembles the full displayed number once every digit has been seen.
- Used for loopback self-check on the board and as the display monitor in benches. It is placed directly on the SEG/DIG nets.

Parameters:
- q_of_7segment_ind, 4: number of digit positions; width of DIG; the number is 4*q_of_7segment_ind bits.
- stable_cycles, 4: consecutive identical samples required before a SEG/DIG combination is accepted (>=2).

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RESET  input  1  reset, synchronous, active-high.
- SEG  input  8  segment lines, active-low, bit order a b c d e f g h (bit7=a, bit0=h/dp).
- DIG  input  q_of_7segment_ind  digit enables, active-low, bit i = digit i (digit 0 = least significant nibble).
- num  output  4*q_of_7segment_ind  last complete decoded number.
- dp  output  q_of_7segment_ind  decimal-point state per digit, latched with num.
- frame_valid  output  1  one-cycle pulse when num/dp update.
- seg_err  output  1  one-cycle pulse: an accepted pattern is not in the hex table.
- dig_err  output  1  one-cycle pulse: an accepted DIG has more than one digit active.
- err_count  output  8  saturating count of seg_err and dig_err events.

Behaviour:
- Reset, synchronous and active-high, on any cycle including mid-frame:
  - num=0, dp=0, frame_valid=0, seg_err=0, dig_err=0, err_count=0.
  - Seen-mask, partial-number register, sample register and run counter are all cleared.
  - The sample register clears to "all lines inactive".
- Input stage: SEG and DIG are inverted to active-high and registered once (s) every cycle.
- Run counter:
  - Increments, saturating at stable_cycles, while s equals its previous value.
  - Reloads to 1 when s changes.
  - An accept event fires exactly once per stable run, on the cycle the counter first reaches stable_cycles. A longer hold does not re-fire.
- On an accept event, by active-high DIG value d:
  - d == 0 (blanking): ignored, no error.
  - d not one-hot: dig_err pulses and the sample is discarded.
  - d one-hot at index i and seg[7:1] in the hex table: the decoded nibble is written to partial[4i+3:4i], seg[0] to dp_partial[i], and seen[i] is set. A digit seen twice is overwritten with the newest value.
  - d one-hot and seg[7:1] not in the table: seg_err pulses; seen[i] and partial are unchanged.
- Hex table, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Frame completion: when an accept makes seen all-ones, on the next edge:
  - num <= partial (including the just-written nibble) and dp <= dp_partial.
  - frame_valid=1 for one cycle.
  - seen clears; partial keeps its contents.
- Digit order is irrelevant; any scan order and any repetition is accepted.
- Latency: the (stable_cycles+1)th rising edge at which a constant SEG/DIG is present registers the resulting num/frame_valid/seg_err/dig_err.
- err_count increments by 1 on each seg_err or dig_err (they are mutually exclusive) and holds at 255.
- Glitches: a value present for fewer than stable_cycles samples never causes an accept and never causes an error.

Test Plan:
- Reset: assert RESET 2 cycles mid-stream -> num=0, dp=0, err_count=0; all pulses low the cycle after.
- Normal frame: drive digits 3,2,1,0 showing "1","A","5","F" (SEG=~pattern, DIG=~(1<<i)), each held 8 cycles -> exactly one frame_valid; num=16'h1A5F (digit 0 = F); dp=0.
- Glitch filter: with stable_cycles=4, insert a 3-cycle SEG=~8'b11111110 on digit 0, then return to "F" -> no accept for "8", no error; the eventual num[3:0]=F.
- Out-of-order and repeats: order 0,0,2,1,3 with digit 0 first "7" then "9" -> one frame_valid after digit 3; num[3:0]=9.
- Errors: SEG pattern abcdefg=1010101 on digit 1 -> seg_err pulse, err_count=1, seen[1] stays 0. DIG active on digits 0 and 2 -> dig_err, err_count=2. 300 bad accepts -> err_count=255.
- Decimal point and blanking: digit 2 shows "8." (SEG active 11111111) and DIG=all-inactive gaps of 10 cycles between digits -> dp=4'b0100, num[11:8]=8, no errors from the gaps.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// Recovers hex digits from active-low 7-seg scan lines and reassembles the displayed number; no backpressure.
// Latency: result registered on the (stable_cycles+1)th edge a constant SEG/DIG is present.
module seven_segment_scan_decoder #(
    parameter int q_of_7segment_ind = 4,
    parameter int stable_cycles     = 4
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [7:0]                     SEG,
    input  logic [q_of_7segment_ind-1:0]   DIG,
    output logic [4*q_of_7segment_ind-1:0] num,
    output logic [q_of_7segment_ind-1:0]   dp,
    output logic                           frame_valid,
    output logic                           seg_err,
    output logic                           dig_err,
    output logic [7:0]                     err_count
);
    localparam int N  = q_of_7segment_ind;
    localparam int RW = $clog2(stable_cycles + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(stable_cycles);

    logic [7:0]     seg_s_q, seg_s_d;
    logic [N-1:0]   dig_s_q, dig_s_d;
    logic [RW-1:0]  run_q, run_d;
    logic           acc_q, acc_d;
    logic [N-1:0]   seen_q, seen_d;
    logic [4*N-1:0] partial_q, partial_d;
    logic [N-1:0]   dp_partial_q, dp_partial_d;
    logic [4*N-1:0] num_q, num_d;
    logic [N-1:0]   dp_q, dp_d;
    logic           frame_valid_q, frame_valid_d;
    logic           seg_err_q, seg_err_d;
    logic           dig_err_q, dig_err_d;
    logic [7:0]     err_count_q, err_count_d;
    logic [4:0]     hex_dec;

    // Returns {valid, nibble} for an abcdefg pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'b1111110: hex_decode = 5'h10;
            7'b0110000: hex_decode = 5'h11;
            7'b1101101: hex_decode = 5'h12;
            7'b1111001: hex_decode = 5'h13;
            7'b0110011: hex_decode = 5'h14;
            7'b1011011: hex_decode = 5'h15;
            7'b1011111: hex_decode = 5'h16;
            7'b1110000: hex_decode = 5'h17;
            7'b1111111: hex_decode = 5'h18;
            7'b1110011: hex_decode = 5'h19;
            7'b1110111: hex_decode = 5'h1A;
            7'b0011111: hex_decode = 5'h1B;
            7'b1001110: hex_decode = 5'h1C;
            7'b0111101: hex_decode = 5'h1D;
            7'b1001111: hex_decode = 5'h1E;
            7'b1000111: hex_decode = 5'h1F;
            default:    hex_decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        seg_s_d       = ~SEG;
        dig_s_d       = ~DIG;
        seen_d        = seen_q;
        partial_d     = partial_q;
        dp_partial_d  = dp_partial_q;
        num_d         = num_q;
        dp_d          = dp_q;
        frame_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        dig_err_d     = 1'b0;
        err_count_d   = err_count_q;
        hex_dec       = hex_decode(seg_s_q[7:1]);

        if ({seg_s_d, dig_s_d} == {seg_s_q, dig_s_q})
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
        else
            run_d = RW'(1);
        // Fires only on the transition into the saturated count, so long holds accept once.
        acc_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);

        if (acc_q && (dig_s_q != '0)) begin
            if ((dig_s_q & (dig_s_q - N'(1))) != '0) begin
                dig_err_d = 1'b1;
            end else if (!hex_dec[4]) begin
                seg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (dig_s_q[i]) begin
                        partial_d[4*i +: 4] = hex_dec[3:0];
                        dp_partial_d[i]     = seg_s_q[0];
                        seen_d[i]           = 1'b1;
                    end
                end
                if (&seen_d) begin
                    num_d         = partial_d;
                    dp_d          = dp_partial_d;
                    frame_valid_d = 1'b1;
                    seen_d        = '0;
                end
            end
        end

        if ((seg_err_d || dig_err_d) && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            seg_s_q       <= '0;
            dig_s_q       <= '0;
            run_q         <= '0;
            acc_q         <= 1'b0;
            seen_q        <= '0;
            partial_q     <= '0;
            dp_partial_q  <= '0;
            num_q         <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            dig_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            seg_s_q       <= seg_s_d;
            dig_s_q       <= dig_s_d;
            run_q         <= run_d;
            acc_q         <= acc_d;
            seen_q        <= seen_d;
            partial_q     <= partial_d;
            dp_partial_q  <= dp_partial_d;
            num_q         <= num_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            dig_err_q     <= dig_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign num         = num_q;
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign dig_err     = dig_err_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: sample-history reference model checked every cycle plus directed literals.
module tb_seven_segment_scan_decoder;
    localparam int N = 4;
    localparam int S = 4;

    logic           CLK   = 1'b0;
    logic           RESET = 1'b1;
    logic [7:0]     SEG   = 8'hFF;
    logic [N-1:0]   DIG   = '1;
    logic [4*N-1:0] num;
    logic [N-1:0]   dp;
    logic           frame_valid, seg_err, dig_err;
    logic [7:0]     err_count;

    seven_segment_scan_decoder #(.q_of_7segment_ind(N), .stable_cycles(S)) dut (
        .CLK(CLK), .RESET(RESET), .SEG(SEG), .DIG(DIG),
        .num(num), .dp(dp), .frame_valid(frame_valid),
        .seg_err(seg_err), .dig_err(dig_err), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int fv_cnt = 0;
    int f0;

    logic [6:0] hex_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: a sample is accepted when the newest S samples agree and the one before differs.
    typedef logic [8+N-1:0] samp_t;
    samp_t          hist[$];
    bit             pend;
    samp_t          pval;
    logic [4*N-1:0] m_num, m_part;
    logic [N-1:0]   m_dp, m_dpp, m_seen;
    logic           m_fv, m_se, m_de;
    int             m_ec;

    task automatic model_accept(input samp_t v);
        logic [7:0]   sg;
        logic [N-1:0] d;
        int idx, nib;
        sg  = v[8+N-1:N];
        d   = v[N-1:0];
        idx = 0;
        nib = -1;
        if (d == '0) return;
        if ($countones(d) != 1) begin
            m_de = 1'b1;
            if (m_ec < 255) m_ec++;
            return;
        end
        for (int i = 0; i < N; i++) if (d[i]) idx = i;
        for (int h = 0; h < 16; h++) if (hex_tab[h] == sg[7:1]) nib = h;
        if (nib < 0) begin
            m_se = 1'b1;
            if (m_ec < 255) m_ec++;
            return;
        end
        m_part[4*idx +: 4] = nib[3:0];
        m_dpp[idx]  = sg[0];
        m_seen[idx] = 1'b1;
        if (m_seen == '1) begin
            m_num  = m_part;
            m_dp   = m_dpp;
            m_fv   = 1'b1;
            m_seen = '0;
        end
    endtask

    always @(posedge CLK) begin
        m_fv = 1'b0;
        m_se = 1'b0;
        m_de = 1'b0;
        if (RESET) begin
            hist.delete();
            pend = 1'b0;
            m_num = '0; m_part = '0; m_dp = '0; m_dpp = '0; m_seen = '0; m_ec = 0;
        end else begin
            if (pend) model_accept(pval);
            pend = 1'b0;
            hist.push_front({~SEG, ~DIG});
            if (hist.size() > S + 1) void'(hist.pop_back());
            if (hist.size() >= S) begin
                bit same;
                same = 1'b1;
                for (int k = 1; k < S; k++) if (hist[k] != hist[0]) same = 1'b0;
                if (same && (hist.size() == S || hist[S] != hist[0])) begin
                    pend = 1'b1;
                    pval = hist[0];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("num",         32'(num),         32'(m_num));
            check("dp",          32'(dp),          32'(m_dp));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("seg_err",     32'(seg_err),     32'(m_se));
            check("dig_err",     32'(dig_err),     32'(m_de));
            check("err_count",   32'(err_count),   32'(m_ec));
            if (frame_valid === 1'b1) fv_cnt++;
        end
    end

    function automatic logic [7:0] pat(input int h);
        logic [6:0] t;
        t = hex_tab[h];
        return {t, 1'b0};
    endfunction

    // Drives active-high segment/digit values (inverted onto the lines) for n edges.
    task automatic drive(input logic [7:0] sa, input logic [N-1:0] da, input int n);
        SEG = ~sa;
        DIG = ~da;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        drive(8'h00, '0, 3);
        chk_en = 1'b1;
        RESET  = 1'b0;
        check("rst_num",   32'(num),         32'h0);
        check("rst_ec",    32'(err_count),   32'h0);
        check("rst_fv",    32'(frame_valid), 32'h0);
        drive(8'h00, '0, 5);

        // normal frame "1A5F"
        f0 = fv_cnt;
        drive(pat(1),  4'b1000, 8);
        drive(pat(10), 4'b0100, 8);
        drive(pat(5),  4'b0010, 8);
        drive(pat(15), 4'b0001, 8);
        check("norm_frames", 32'(fv_cnt - f0), 32'd1);
        check("norm_num",    32'(num),         32'h1A5F);
        check("norm_dp",     32'(dp),          32'h0);

        // glitches on the final digit must not complete the frame
        f0 = fv_cnt;
        drive(pat(2), 4'b1000, 6);
        drive(pat(4), 4'b0100, 6);
        drive(pat(6), 4'b0010, 6);
        drive(8'hFE,       4'b0001, 3);
        drive(8'b10101010, 4'b0001, 3);
        check("glitch_early", 32'(fv_cnt - f0), 32'd0);
        drive(pat(15), 4'b0001, 8);
        check("glitch_frames", 32'(fv_cnt - f0), 32'd1);
        check("glitch_nib",    32'(num[3:0]),    32'hF);
        check("glitch_num",    32'(num),         32'h246F);
        check("glitch_noerr",  32'(err_count),   32'h0);

        // out-of-order with a repeated digit
        f0 = fv_cnt;
        drive(pat(7),  4'b0001, 6);
        drive(pat(9),  4'b0001, 6);
        drive(pat(3),  4'b0100, 6);
        drive(pat(12), 4'b0010, 6);
        check("ooo_early", 32'(fv_cnt - f0), 32'd0);
        drive(pat(0), 4'b1000, 6);
        check("ooo_frames", 32'(fv_cnt - f0), 32'd1);
        check("ooo_num",    32'(num),         32'h03C9);

        // reset mid-digit
        drive(pat(8), 4'b1000, 2);
        RESET = 1'b1;
        drive(pat(8), 4'b1000, 2);
        RESET = 1'b0;
        check("rst2_num", 32'(num),       32'h0);
        check("rst2_dp",  32'(dp),        32'h0);
        check("rst2_ec",  32'(err_count), 32'h0);
        drive(8'h00, '0, 6);

        // errors
        drive(8'b10101010, 4'b0010, 6);
        check("seg_err_cnt", 32'(err_count), 32'd1);
        f0 = fv_cnt;
        drive(pat(0), 4'b0001, 6);
        drive(pat(0), 4'b0100, 6);
        drive(pat(0), 4'b1000, 6);
        check("seen1_clear", 32'(fv_cnt - f0), 32'd0);
        drive(pat(1), 4'b0010, 6);
        check("seen1_frame", 32'(fv_cnt - f0), 32'd1);
        check("seen1_num",   32'(num),         32'h0010);
        drive(pat(4), 4'b0101, 6);
        check("dig_err_cnt", 32'(err_count), 32'd2);
        for (int r = 0; r < 150; r++) begin
            drive(8'b10101010, 4'b0010, 4);
            drive(8'b11110000, 4'b0010, 4);
        end
        drive(8'h00, '0, 4);
        check("err_sat", 32'(err_count), 32'd255);

        // decimal point and blanking gaps
        RESET = 1'b1;
        drive(8'h00, '0, 2);
        RESET = 1'b0;
        f0 = fv_cnt;
        drive(pat(1), 4'b0001, 6);  drive(8'h00, '0, 10);
        drive(pat(2), 4'b0010, 6);  drive(8'h00, '0, 10);
        drive(8'hFF,  4'b0100, 6);  drive(8'h00, '0, 10);
        drive(pat(3), 4'b1000, 6);  drive(8'h00, '0, 10);
        check("bl_frames", 32'(fv_cnt - f0), 32'd1);
        check("bl_dp",     32'(dp),          32'b0100);
        check("bl_nib",    32'(num[11:8]),   32'h8);
        check("bl_num",    32'(num),         32'h3821);
        check("bl_err",    32'(err_count),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
